// File: rtl/multi_player_game_clock.sv
// multi_player_game_clock
//   N-player game clock controller. Holds one countdown timer per player and a
//   one-hot turn pointer. A press by the player whose clock is running hands the
//   turn to the next player in order 0 -> 1 -> .. -> N-1 -> 0. The block also
//   provides a tick prescaler, a Fischer increment, pause, flag-fall detection
//   and a WAIT state for ambiguous presses.
//
// Ports
//   clk_i         system clock; all logic is on the rising edge
//   reset_n_i     synchronous reset, active low
//   press_i       player buttons (level, already debounced and synchronous)
//   pause_i       level; freezes the running timer while high
//   new_game_i    pulse; returns to IDLE and reloads every timer
//   active_o      one-hot: the player whose timer runs (0 when none)
//   time_bus_o    player i timer at [i*TIME_W +: TIME_W]
//   flag_o        flag_o[i] set when player i's timer ran out
//   running_o     state is RUN
//   clr_o         state is IDLE
//   game_over_o   state is DONE
module multi_player_game_clock #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 16,
  parameter int TICK_DIV  = 1000,
  parameter int INIT_TIME = 300,
  parameter int INC_TIME  = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [N_PLAYERS-1:0]          press_i,
  input  logic                          pause_i,
  input  logic                          new_game_i,
  output logic [N_PLAYERS-1:0]          active_o,
  output logic [N_PLAYERS*TIME_W-1:0]   time_bus_o,
  output logic [N_PLAYERS-1:0]          flag_o,
  output logic                          running_o,
  output logic                          clr_o,
  output logic                          game_over_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] INIT_T    = TIME_W'(INIT_TIME);
  localparam logic [TIME_W:0]   INC_EXT   = (TIME_W + 1)'(INC_TIME);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WAIT, S_PAUSE, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [N_PLAYERS-1:0]         active_q, active_d;
  logic [N_PLAYERS-1:0]         flag_q, flag_d;
  logic [N_PLAYERS-1:0]         press_q;
  logic [PW-1:0]                presc_q, presc_d;
  logic [N_PLAYERS*TIME_W-1:0]  timers_flat;
  logic [N_PLAYERS-1:0]         pe;
  logic [N_PLAYERS-1:0]         dec_mask, inc_mask;
  logic                         reload;
  logic                         tick;
  logic [TIME_W-1:0]            active_time;

  function automatic logic one_hot(input logic [N_PLAYERS-1:0] v);
    return (v != '0) && ((v & (v - N_PLAYERS'(1))) == '0);
  endfunction

  // Next player in turn order: rotate the one-hot vector up by one.
  function automatic logic [N_PLAYERS-1:0] rotl(input logic [N_PLAYERS-1:0] v);
    return {v[N_PLAYERS-2:0], v[N_PLAYERS-1]};
  endfunction

  assign pe   = press_i & ~press_q;
  assign tick = (presc_q == TICK_LAST);

  always_comb begin
    active_time = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (active_q[i]) active_time = timers_flat[i*TIME_W +: TIME_W];
    end
  end

  // State register (also carries turn pointer, flags, prescaler, press history)
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      flag_q   <= '0;
      presc_q  <= '0;
      press_q  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      flag_q   <= flag_d;
      presc_q  <= presc_d;
      press_q  <= press_i;
    end
  end

  // Next-state logic. Timer updates are expressed as masks consumed per player.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    flag_d   = flag_q;
    presc_d  = presc_q;
    reload   = 1'b0;
    dec_mask = '0;
    inc_mask = '0;
    if (new_game_i) begin
      state_d  = S_IDLE;
      active_d = '0;
      flag_d   = '0;
      presc_d  = '0;
      reload   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          reload = 1'b1;
          if (one_hot(pe)) begin
            state_d  = S_RUN;
            active_d = rotl(pe);
            presc_d  = '0;
          end else if (pe != '0) begin
            state_d  = S_WAIT;
            active_d = '0;
          end
        end
        S_RUN: begin
          // A timer already at 0 (INIT_TIME==0) also flags on its first tick.
          if (tick && (active_time <= TIME_W'(1))) begin
            state_d  = S_DONE;
            dec_mask = active_q;
            flag_d   = flag_q | active_q;
            active_d = '0;
          end else if (pause_i) begin
            state_d = S_PAUSE;
          end else if ((pe != '0) && !one_hot(pe)) begin
            state_d  = S_WAIT;
            active_d = '0;
          end else if (pe == active_q) begin
            inc_mask = active_q;
            active_d = rotl(active_q);
            presc_d  = '0;
          end else begin
            // No press, or a press by a waiting player: just count.
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) dec_mask = active_q;
          end
        end
        S_WAIT: begin
          // Resolved on press level, not edges: exactly one button held.
          if (one_hot(press_i)) begin
            state_d  = S_RUN;
            active_d = rotl(press_i);
            presc_d  = '0;
          end
        end
        S_PAUSE: begin
          if (!pause_i) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // Per-player timers
  generate
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_timer
      logic [TIME_W-1:0] timer_q, timer_d;
      logic [TIME_W:0]   sum;

      assign sum = {1'b0, timer_q} + INC_EXT;

      always_comb begin
        timer_d = timer_q;
        if (reload) begin
          timer_d = INIT_T;
        end else if (inc_mask[gi]) begin
          timer_d = sum[TIME_W] ? '1 : sum[TIME_W-1:0];
        end else if (dec_mask[gi] && (timer_q != '0)) begin
          timer_d = timer_q - TIME_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (!reset_n_i) timer_q <= INIT_T;
        else            timer_q <= timer_d;
      end

      assign timers_flat[gi*TIME_W +: TIME_W] = timer_q;
    end
  endgenerate

  // Output decode (all sourced from registers)
  always_comb begin
    active_o    = active_q;
    flag_o      = flag_q;
    time_bus_o  = timers_flat;
    running_o   = (state_q == S_RUN);
    clr_o       = (state_q == S_IDLE);
    game_over_o = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_multi_player_game_clock.sv
// Directed bench for multi_player_game_clock. Instance A: 3 players, 8-bit
// timers, TICK_DIV=4, INIT=5, INC=2. Instance B: same but 4-bit timers and
// INIT=14, used for increment saturation. Stimulus pushes hand-computed
// snapshots tagged with the cycle they must hold; a monitor compares them.
module tb_multi_player_game_clock;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic [2:0]  press_a = '0, press_b = '0;
  logic        pause_a = 1'b0, pause_b = 1'b0;
  logic        ng_a = 1'b0, ng_b = 1'b0;

  logic [2:0]  active_a, flag_a, active_b, flag_b;
  logic [23:0] tbus_a;
  logic [11:0] tbus_b;
  logic        run_a, clr_a, go_a, run_b, clr_b, go_b;

  multi_player_game_clock #(.N_PLAYERS(3), .TIME_W(8), .TICK_DIV(4),
                            .INIT_TIME(5), .INC_TIME(2)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .press_i(press_a), .pause_i(pause_a),
    .new_game_i(ng_a), .active_o(active_a), .time_bus_o(tbus_a), .flag_o(flag_a),
    .running_o(run_a), .clr_o(clr_a), .game_over_o(go_a));

  multi_player_game_clock #(.N_PLAYERS(3), .TIME_W(4), .TICK_DIV(4),
                            .INIT_TIME(14), .INC_TIME(2)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .press_i(press_b), .pause_i(pause_b),
    .new_game_i(ng_b), .active_o(active_b), .time_bus_o(tbus_b), .flag_o(flag_b),
    .running_o(run_b), .clr_o(clr_b), .game_over_o(go_b));

  typedef struct packed {
    int           cyc;
    logic         dut;
    logic [2:0]   act;
    logic [23:0]  tb;
    logic [2:0]   flg;
    logic [2:0]   st;    // {running, clr, game_over}
    logic [95:0]  name;
  } exp_t;

  exp_t sb[$];
  int   pc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) pc <= pc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect a snapshot k edges from now.
  task automatic E(input int k, input logic [95:0] nm, input logic d,
                   input logic [2:0] act, input int t0, input int t1, input int t2,
                   input logic [2:0] flg, input logic [2:0] st);
    exp_t e;
    e.cyc  = pc + k;
    e.dut  = d;
    e.act  = act;
    e.tb   = d ? {12'h000, 4'(t2), 4'(t1), 4'(t0)} : {8'(t2), 8'(t1), 8'(t0)};
    e.flg  = flg;
    e.st   = st;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    int i;
    exp_t e;
    logic [2:0]  a_act, a_flg, a_st;
    logic [23:0] a_tb;
    i = 0;
    while (i < sb.size()) begin
      e = sb[i];
      if (e.cyc <= pc) begin
        if (e.dut) begin
          a_act = active_b; a_tb = {12'h000, tbus_b}; a_flg = flag_b; a_st = {run_b, clr_b, go_b};
        end else begin
          a_act = active_a; a_tb = tbus_a; a_flg = flag_a; a_st = {run_a, clr_a, go_a};
        end
        checks++;
        if (e.cyc != pc) begin
          errors++;
          $display("FAIL %0s: missed at cycle %0d, required cycle %0d", e.name, pc, e.cyc);
        end else if (a_act !== e.act || a_tb !== e.tb || a_flg !== e.flg || a_st !== e.st) begin
          errors++;
          $display("FAIL %0s: active=%b time=%h flag=%b st=%b, required active=%b time=%h flag=%b st=%b",
                   e.name, a_act, a_tb, a_flg, a_st, e.act, e.tb, e.flg, e.st);
        end else begin
          $display("cyc %0d %0s ok: active=%b time=%h flag=%b st=%b", pc, e.name, a_act, a_tb, a_flg, a_st);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    tick(2);
    reset_n = 1'b1;
    E(1, "reset", 0, 3'b000, 5, 5, 5, 3'b000, 3'b010);                 tick(1);
    // 1: first press starts player 1
    press_a = 3'b001;
    E(1, "t1_run", 0, 3'b010, 5, 5, 5, 3'b000, 3'b100);                tick(1);
    press_a = 3'b000;
    E(3, "t1_pre", 0, 3'b010, 5, 5, 5, 3'b000, 3'b100);
    E(4, "t1_dec", 0, 3'b010, 5, 4, 5, 3'b000, 3'b100);                tick(4);
    // 2: non-active press ignored, active press hands over with increment
    press_a = 3'b100;
    E(1, "t2_ign", 0, 3'b010, 5, 4, 5, 3'b000, 3'b100);                tick(1);
    press_a = 3'b000;                                                  tick(1);
    press_a = 3'b010;
    E(1, "t2_hand", 0, 3'b100, 5, 6, 5, 3'b000, 3'b100);               tick(1);
    press_a = 3'b000;
    E(3, "t2_pre", 0, 3'b100, 5, 6, 5, 3'b000, 3'b100);
    E(4, "t2_dec", 0, 3'b100, 5, 6, 4, 3'b000, 3'b100);                tick(4);
    // 3: ambiguous press -> WAIT, frozen, resolved by a single held button
    press_a = 3'b101;
    E(1, "t3_wait", 0, 3'b000, 5, 6, 4, 3'b000, 3'b000);
    E(11, "t3_frz", 0, 3'b000, 5, 6, 4, 3'b000, 3'b000);               tick(11);
    press_a = 3'b001;
    E(1, "t3_resume", 0, 3'b010, 5, 6, 4, 3'b000, 3'b100);             tick(1);
    press_a = 3'b000; ng_a = 1'b1;
    E(1, "ng_idle", 0, 3'b000, 5, 5, 5, 3'b000, 3'b010);               tick(1);
    // 4: player 1 runs out; flag-fall beats a simultaneous active press
    ng_a = 1'b0; press_a = 3'b001;
    E(1, "t4_run", 0, 3'b010, 5, 5, 5, 3'b000, 3'b100);                tick(1);
    press_a = 3'b000;
    E(19, "t4_last", 0, 3'b010, 5, 1, 5, 3'b000, 3'b100);              tick(19);
    press_a = 3'b010;
    E(1, "t4_flag", 0, 3'b000, 5, 0, 5, 3'b010, 3'b001);               tick(1);
    press_a = 3'b000;                                                  tick(1);
    press_a = 3'b100; pause_a = 1'b1;                                  tick(1);
    press_a = 3'b000; pause_a = 1'b0;
    E(1, "t4_hold", 0, 3'b000, 5, 0, 5, 3'b010, 3'b001);               tick(1);
    // 6: pause retains player and prescaler; reset mid-run
    ng_a = 1'b1;
    E(1, "t6_idle", 0, 3'b000, 5, 5, 5, 3'b000, 3'b010);               tick(1);
    ng_a = 1'b0; press_a = 3'b001;
    E(1, "t6_run", 0, 3'b010, 5, 5, 5, 3'b000, 3'b100);                tick(1);
    press_a = 3'b000;                                                  tick(2);
    pause_a = 1'b1;
    E(1, "t6_pause", 0, 3'b010, 5, 5, 5, 3'b000, 3'b000);
    E(8, "t6_frz", 0, 3'b010, 5, 5, 5, 3'b000, 3'b000);                tick(8);
    pause_a = 1'b0;
    E(1, "t6_resume", 0, 3'b010, 5, 5, 5, 3'b000, 3'b100);
    E(2, "t6_pre", 0, 3'b010, 5, 5, 5, 3'b000, 3'b100);
    E(3, "t6_dec", 0, 3'b010, 5, 4, 5, 3'b000, 3'b100);                tick(3);
    reset_n = 1'b0;
    E(1, "t6_reset", 0, 3'b000, 5, 5, 5, 3'b000, 3'b010);              tick(1);
    reset_n = 1'b1;                                                    tick(1);
    // 5: increment saturates on the 4-bit instance
    press_b = 3'b100;
    E(1, "t5_run", 1, 3'b001, 14, 14, 14, 3'b000, 3'b100);             tick(1);
    press_b = 3'b000;                                                  tick(1);
    press_b = 3'b001;
    E(1, "t5_sat", 1, 3'b010, 15, 14, 14, 3'b000, 3'b100);             tick(1);
    press_b = 3'b000;
    E(3, "t5_pre", 1, 3'b010, 15, 14, 14, 3'b000, 3'b100);
    E(4, "t5_dec", 1, 3'b010, 15, 13, 14, 3'b000, 3'b100);             tick(4);

    for (int w = 0; w < 20 && sb.size() > 0; w++) tick(1);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %0s: timeout, still pending at cycle %0d, required cycle %0d",
               sb[0].name, pc, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
